// File: rtl/diff_pkg.sv
// Shared types and constants for the difftest commit packer.
// commit_rec_t is the retire/commit record (274 bits, pc in the MSBs).
// The packer reads only wen/wdest/wdata; every other field passes through untouched.
package diff_pkg;

  localparam int REC_W = 274;
  localparam int LANES = 4;
  localparam int NGPR  = 32;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        is_tlbfill;
    logic [4:0]  tlbfill_index;
    logic        is_cnt;
    logic [63:0] timer64;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        csr_rstat;
    logic [31:0] csr_data;
  } commit_rec_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/diff_commit_fifo.sv
// In-order circular buffer that takes up to 4 pushes and 4 pops per cycle.
// The sparse push slots are packed together in slot order as they are written.
// Ports:
//   clock, resetn   : clock and asynchronous active-low reset (resets pointers and count only)
//   push_en         : accept the valid push slots on this edge
//   push_valid/rec  : sparse push slots, slot 0 oldest
//   pop_n           : entries popped on this edge (caller guarantees pop_n <= count)
//   count           : occupancy before the edge
//   head            : the 4 oldest entries (only the first min(count,4) are meaningful)
module diff_commit_fifo
  import diff_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push_en,
  input  logic [LANES-1:0]           push_valid,
  input  commit_rec_t                push_rec [LANES],
  input  logic [2:0]                 pop_n,
  output logic [$clog2(DEPTH):0]     count,
  output commit_rec_t                head [LANES]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  commit_rec_t    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic [2:0]     n_push;
  logic [PW-1:0]  slot_addr [LANES];

  // Each valid slot lands at wr_ptr plus the number of valid slots below it.
  always_comb begin
    logic [2:0] acc;
    acc = 3'd0;
    for (int i = 0; i < LANES; i++) begin
      slot_addr[i] = wr_ptr + PW'(acc);
      acc = acc + 3'(push_valid[i]);
    end
    n_push = push_en ? popcount4(push_valid) : 3'd0;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en && push_valid[i]) mem[slot_addr[i]] <= push_rec[i];
    end
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(n_push);
      rd_ptr  <= rd_ptr + PW'(pop_n);
      count_q <= count_q + CW'(n_push) - CW'(pop_n);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) head[i] = mem[rd_ptr + PW'(i)];
  end

  assign count = count_q;

endmodule

// File: rtl/diff_commit_packer.sv
// Producer side of the difftest commit interface. Buffers sparse retire slots
// in order and drains them as contiguous 4-lane commit batches. It also keeps a
// shadow GPR file that reflects the state after the batch shown on out_*.
// Ports:
//   clock, resetn : clock, asynchronous active-low reset
//   in_valid/rec  : up to 4 retire slots per cycle, slot 0 oldest, may be sparse
//   in_ready      : all 4 slots are accepted on the next edge when high
//   drain_en      : consumer enable; 0 freezes draining
//   coreid        : constant CORE_ID
//   out_valid/index/rec : registered commit lanes, valid contiguous from lane 0
//   gpr           : shadow r0..r31, 64 bits each, r0 at [63:0]
module diff_commit_packer
  import diff_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CORE_ID = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*REC_W-1:0] in_rec,
  output logic                   in_ready,
  input  logic                   drain_en,
  output logic [7:0]             coreid,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*8-1:0]     out_index,
  output logic [LANES*REC_W-1:0] out_rec,
  output logic [NGPR*64-1:0]     gpr
);

  localparam int CW = $clog2(DEPTH) + 1;

  commit_rec_t   slot_rec [LANES];
  commit_rec_t   head     [LANES];
  logic [CW-1:0] count;
  logic [2:0]    n_out;
  logic [63:0]   gpr_q [NGPR];

  always_comb begin
    for (int i = 0; i < LANES; i++) slot_rec[i] = in_rec[i*REC_W +: REC_W];
  end

  // Room for a full 4-slot group is judged from the registered count only.
  assign in_ready = (count <= CW'(DEPTH - LANES));

  always_comb begin
    n_out = 3'd0;
    if (drain_en) n_out = (count >= CW'(LANES)) ? 3'd4 : 3'(count);
  end

  diff_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push_en    (in_ready),
    .push_valid (in_valid),
    .push_rec   (slot_rec),
    .pop_n      (n_out),
    .count      (count),
    .head       (head)
  );

  // Output lanes and shadow GPR load together on every edge. Lanes are
  // applied in order, so the highest lane writing a register wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= '0;
      out_index <= '0;
      out_rec   <= '0;
      for (int r = 0; r < NGPR; r++) gpr_q[r] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        out_index[i*8 +: 8] <= 8'(i);
        if (3'(i) < n_out) begin
          out_valid[i]              <= 1'b1;
          out_rec[i*REC_W +: REC_W] <= head[i];
          if (head[i].wen && head[i].wdest != 8'd0 && head[i].wdest < 8'(NGPR))
            gpr_q[head[i].wdest[4:0]] <= head[i].wdata;
        end else begin
          out_valid[i]              <= 1'b0;
          out_rec[i*REC_W +: REC_W] <= '0;
        end
      end
    end
  end

  for (genvar r = 0; r < NGPR; r++) begin : g_gpr
    assign gpr[r*64 +: 64] = gpr_q[r];
  end

  assign coreid = 8'(CORE_ID);

endmodule

// File: tb/tb_diff_commit_packer.sv
module tb_diff_commit_packer;
  import diff_pkg::*;

  logic                   clock;
  logic                   resetn;
  logic [LANES-1:0]       in_valid;
  logic [LANES*REC_W-1:0] in_rec;
  logic                   in_ready;
  logic                   drain_en;
  logic [7:0]             coreid;
  logic [LANES-1:0]       out_valid;
  logic [LANES*8-1:0]     out_index;
  logic [LANES*REC_W-1:0] out_rec;
  logic [NGPR*64-1:0]     gpr;

  int errors = 0;
  int checks = 0;

  diff_commit_packer #(.DEPTH(16), .CORE_ID(0)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_rec    (in_rec),
    .in_ready  (in_ready),
    .drain_en  (drain_en),
    .coreid    (coreid),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_rec   (out_rec),
    .gpr       (gpr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic commit_rec_t mk(input logic [63:0] pc, input logic wen,
                                     input logic [7:0] wdest, input logic [63:0] wdata,
                                     input logic skip);
    commit_rec_t r;
    r = '0;
    r.pc = pc; r.instr = pc[31:0] ^ 32'h5a5a_0000; r.wen = wen;
    r.wdest = wdest; r.wdata = wdata; r.skip = skip;
    return r;
  endfunction

  function automatic logic [63:0] pc_of(input int k);
    return 64'h1000 + 64'(k) * 4;
  endfunction

  function automatic commit_rec_t lane_rec(input int i);
    return out_rec[i*REC_W +: REC_W];
  endfunction

  function automatic logic [63:0] gpr_reg(input int r);
    return gpr[r*64 +: 64];
  endfunction

  // Drive n dense slots holding sequence numbers k..k+n-1.
  task automatic push_group(input int k, input int n);
    in_rec = '0;
    for (int i = 0; i < n; i++) in_rec[i*REC_W +: REC_W] = mk(pc_of(k + i), 1'b0, 8'd0, 64'd0, 1'b0);
    in_valid = 4'((1 << n) - 1);
  endtask

  task automatic check_batch(input string tag, input logic [3:0] ve, input int k);
    commit_rec_t r;
    chk({tag, "_valid"}, 64'(out_valid), 64'(ve));
    for (int i = 0; i < LANES; i++) begin
      r = lane_rec(i);
      if (ve[i]) chk({tag, "_pc"}, r.pc, pc_of(k + i));
    end
  endtask

  initial begin
    commit_rec_t r;
    resetn = 1'b0; in_valid = '0; in_rec = '0; drain_en = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_gpr_zero", 64'(gpr === '0), 64'd1);
    chk("coreid", 64'(coreid), 64'd0);
    resetn = 1'b1;

    // Sparse slots 1 and 3
    drain_en = 1'b1;
    in_rec = '0;
    in_rec[1*REC_W +: REC_W] = mk(64'h1c00_0008, 1'b0, 8'd0, 64'd0, 1'b0);
    in_rec[3*REC_W +: REC_W] = mk(64'h1c00_000c, 1'b0, 8'd0, 64'd0, 1'b0);
    in_valid = 4'b1010;
    tick();
    in_valid = '0;
    chk("sparse_latency1", 64'(out_valid), 64'd0);
    tick();
    chk("sparse_valid", 64'(out_valid), 64'h3);
    r = lane_rec(0); chk("sparse_lane0_pc", r.pc, 64'h1c00_0008);
    r = lane_rec(1); chk("sparse_lane1_pc", r.pc, 64'h1c00_000c);
    chk("sparse_index", 64'(out_index), 64'h0302_0100);
    chk("sparse_lane2_zero", 64'(lane_rec(2) === '0), 64'd1);
    tick();
    chk("sparse_drained", 64'(out_valid), 64'd0);

    // Same-batch GPR ordering, r0 protection
    in_rec = '0;
    in_rec[0*REC_W +: REC_W] = mk(64'h2000, 1'b1, 8'd4, 64'h11, 1'b0);
    in_rec[1*REC_W +: REC_W] = mk(64'h2004, 1'b1, 8'd0, 64'hff, 1'b0);
    in_rec[2*REC_W +: REC_W] = mk(64'h2008, 1'b1, 8'd4, 64'h22, 1'b0);
    in_valid = 4'b0111;
    tick();
    in_valid = '0;
    tick();
    chk("gpr_batch_valid", 64'(out_valid), 64'h7);
    chk("gpr_r4_last_lane", gpr_reg(4), 64'h22);
    chk("gpr_r0_zero", gpr_reg(0), 64'd0);
    // skip record still writes; wdest 40 (aliases r8 in low bits) is ignored
    in_rec = '0;
    in_rec[0*REC_W +: REC_W] = mk(64'h200c, 1'b1, 8'd5, 64'h7, 1'b1);
    in_rec[1*REC_W +: REC_W] = mk(64'h2010, 1'b1, 8'd40, 64'hdead, 1'b0);
    in_valid = 4'b0011;
    tick();
    in_valid = '0;
    tick();
    chk("gpr_r5_skip", gpr_reg(5), 64'h7);
    chk("gpr_r8_oob_ignored", gpr_reg(8), 64'd0);
    chk("gpr_r4_kept", gpr_reg(4), 64'h22);
    tick();

    // Backpressure
    drain_en = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk("bp_ready_before_push", 64'(in_ready), 64'd1);
      push_group(4 * g, 4);
      tick();
    end
    chk("bp_full_not_ready", 64'(in_ready), 64'd0);
    push_group(16, 4);
    tick();
    chk("bp_held_not_ready", 64'(in_ready), 64'd0);
    chk("bp_frozen", 64'(out_valid), 64'd0);
    drain_en = 1'b1;
    tick();
    check_batch("bp_b0", 4'hf, 0);
    chk("bp_ready_again", 64'(in_ready), 64'd1);
    tick();
    in_valid = '0;
    check_batch("bp_b1", 4'hf, 4);
    tick(); check_batch("bp_b2", 4'hf, 8);
    tick(); check_batch("bp_b3", 4'hf, 12);
    tick(); check_batch("bp_b4", 4'hf, 16);
    tick(); chk("bp_empty", 64'(out_valid), 64'd0);

    // Sustained 4-in/4-out across many pointer wraps
    for (int c = 0; c < 40; c++) begin
      push_group(100 + 4 * c, 4);
      tick();
      if (c == 0) chk("wrap_first", 64'(out_valid), 64'd0);
      else check_batch("wrap", 4'hf, 100 + 4 * (c - 1));
      chk("wrap_ready", 64'(in_ready), 64'd1);
    end
    in_valid = '0;
    tick(); check_batch("wrap_tail", 4'hf, 256);
    tick(); chk("wrap_empty", 64'(out_valid), 64'd0);

    // Partial drain from count 6
    drain_en = 1'b0;
    push_group(300, 4); tick();
    push_group(304, 2); tick();
    in_valid = '0;
    drain_en = 1'b1;
    tick(); check_batch("part_b0", 4'hf, 300);
    tick(); check_batch("part_b1", 4'h3, 304);
    tick(); chk("part_empty", 64'(out_valid), 64'd0);

    // Reset mid-stream with count 9 and a live batch on the outputs
    drain_en = 1'b0;
    push_group(400, 4); tick();
    push_group(404, 4); tick();
    push_group(408, 4); tick();
    drain_en = 1'b1;
    push_group(412, 1);
    tick();
    check_batch("mid_b0", 4'hf, 400);
    in_valid = '0;
    drain_en = 1'b0;
    resetn = 1'b0;
    #2;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_gpr_zero", 64'(gpr === '0), 64'd1);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_index", 64'(out_index), 64'd0);
    tick();
    resetn = 1'b1;
    drain_en = 1'b1;
    tick();
    chk("post_rst_no_output", 64'(out_valid), 64'd0);
    chk("post_rst_index", 64'(out_index), 64'h0302_0100);
    tick();
    chk("post_rst_still_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/diff_commit_packer.md
Name: diff_commit_packer

Overview:
Producer side of the difftest commit interface. Accepts up to 4 retire slots per cycle from the ROB (sparse, in program order by slot), buffers them in an in-order FIFO, and drains them as contiguous 4-lane commit batches with lane indices. Maintains a shadow architectural GPR file updated in commit order. This lets the bridge's per-lane commit inputs and GPR-state inputs be driven directly from registered outputs.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >= 8)
CORE_ID, 0, constant driven on coreid

Ports:
clock  in  1  core clock
resetn  in  1  reset, asynchronous, active-low
in_valid  in  4  retire slot valid; slot 0 oldest; may be sparse
in_rec  in  4*REC_W  retire records, slot i at bits [i*REC_W +: REC_W]
in_ready  out  1  all 4 slots accepted this cycle when high
drain_en  in  1  difftest consumer enabled; 0 freezes draining
coreid  out  8  CORE_ID
out_valid  out  4  lane valid, always contiguous from lane 0
out_index  out  32  lane index, 8 bits per lane
out_rec  out  4*REC_W  commit records per lane
gpr  out  2048  shadow GPR r0..r31, 64 bits each, r0 at [63:0]

Behaviour:
- Reset (async, resetn=0): FIFO rd/wr pointers=0, count=0, out_valid=0, out_index=0, out_rec=0, gpr all 0. in_ready=1 during and after reset.
- in_ready = (count <= DEPTH-4), using the pre-edge count. It is combinational from registered count only.
- Enqueue: on a rising edge with in_ready=1, the valid slots are compacted in slot order and written at wr_ptr. n_in = popcount(in_valid). If in_ready=0, nothing is accepted; the ROB holds its slots.
- Dequeue: on a rising edge with drain_en=1, n_out = min(count,4) entries are popped from rd_ptr.
- Output registers are loaded on every edge. Lane i < n_out gets the i-th popped record, out_valid[i]=1, out_index[i]=i. Other lanes: valid=0, rec=0, index=i.
- drain_en=0 or count=0: out_valid=0 on the next edge.
- Entries enqueued on edge t are poppable at edge t+1 at the earliest. Minimum in-to-out latency is 2 edges.
- Simultaneous enqueue and dequeue: count_next = count + n_in - n_out. Pointers advance mod DEPTH; wrap is via natural overflow.
- Shadow GPR:
  - Updated on the same edge as the output load, applying popped lanes in lane order.
  - A lane writes only if wen=1 and 0 < wdest < 32. wdest 0 or >= 32 is ignored, so r0 stays 0.
  - If several lanes in one batch write the same register, the highest lane wins.
  - skip=1 records still update the GPR.
  - gpr therefore reflects architectural state after the batch currently on out_*.
- Records are opaque except wen, wdest and wdata, which the shadow GPR reads.
- No flush input. Squashed instructions never reach in_valid.

Decomposition:
- Package diff_pkg holds:
  - REC_W = 274.
  - Packed commit_rec_t, MSB→LSB: pc[64], instr[32], skip, is_tlbfill, tlbfill_index[5], is_cnt, timer64[64], wen, wdest[8], wdata[64], csr_rstat, csr_data[32].
  - Constants LANES=4 and NGPR=32.
- One sub-module, diff_commit_fifo: multi-push/multi-pop circular buffer with compaction on push, exposing count and the 4 head entries.
- Packing, output registers and the shadow GPR stay in the top module.

Test Plan:
- Reset: hold resetn=0 mid-stream with count=9 → out_valid=0, gpr all 0, in_ready=1 immediately. After release, no output until new input arrives.
- Sparse slots: in_valid=4'b1010 with pc 0x1c000008 (slot1) and 0x1c00000c (slot3), drain_en=1 → 2 edges later out_valid=4'b0011, lane0 pc 0x1c000008, lane1 pc 0x1c00000c, index 0/1.
- GPR ordering: one batch with lane0 r4=0x11, lane2 r4=0x22, lane1 wdest0 data 0xff → gpr r4=0x22, r0=0. A later skip=1 write r5=0x7 → r5=0x7.
- Backpressure: drain_en=0, push 4/cycle → in_ready=1 after 3 pushes (count=12), 0 after 4th (count=16). Extra slots held, not lost. Then drain_en=1 → 4 lanes/cycle in original pc order.
- Wrap: sustained 4-in/4-out for 40 cycles with incrementing pc → count constant, pointers wrap, pc sequence gap-free and in order.
- Partial drain: count=6, drain_en=1 → batch of 4 (out_valid=4'b1111), then batch of 2 (4'b0011), then 0.
